tensor_core_mma_seq: RTL and testbench

//   Parametrised sequential tensor-core MMA engine: D = A x B + C over DIMxDIM signed tiles.

---
 rtl/tensor_core_mma_seq_if.sv | 30 +++
 rtl/tensor_core_mma_seq.sv | 135 +++++++++++++
 tb/tb_tensor_core_mma_seq.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tensor_core_mma_seq_if.sv
// Operand/result valid-ready bundle for tensor_core_mma_seq.
// master = operand producer / result consumer, slave = the MMA engine.
interface tensor_core_mma_seq_if #(
  parameter int unsigned DIM       = 4,
  parameter int unsigned IN_WIDTH  = 8,
  parameter int unsigned ACC_WIDTH = 32
);
  localparam int unsigned AB_W = DIM * DIM * IN_WIDTH;
  localparam int unsigned CD_W = DIM * DIM * ACC_WIDTH;

  logic            in_valid;
  logic            in_ready;
  logic            acc_en;
  logic [AB_W-1:0] a_in;
  logic [AB_W-1:0] b_in;
  logic [CD_W-1:0] c_in;
  logic            out_valid;
  logic            out_ready;
  logic [CD_W-1:0] d_out;

  modport master (
    output in_valid, acc_en, a_in, b_in, c_in, out_ready,
    input  in_ready, out_valid, d_out
  );

  modport slave (
    input  in_valid, acc_en, a_in, b_in, c_in, out_ready,
    output in_ready, out_valid, d_out
  );
endinterface

// File: rtl/tensor_core_mma_seq.sv
// Sequential DIMxDIM MMA engine, D = A x B + C, one rank-1 update per cycle.
// Optional macro TC_SATURATE_EN: clamp each partial sum and report a sticky overflow.
module tensor_core_mma_seq #(
  parameter int unsigned DIM       = 4,
  parameter int unsigned IN_WIDTH  = 8,
  parameter int unsigned ACC_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mma_enable,
  tensor_core_mma_seq_if.slave  bus,
  output logic                  busy,
  output logic                  overflow
);
  localparam int unsigned NEL   = DIM * DIM;
  localparam int unsigned AB_W  = NEL * IN_WIDTH;
  localparam int unsigned CD_W  = NEL * ACC_WIDTH;
  localparam int unsigned PW    = 2 * IN_WIDTH;
  localparam int unsigned KW    = $clog2(DIM + 1);
  localparam int          DIM_I = int'(DIM);
  localparam int          NEL_I = int'(NEL);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_DONE    = 2'd2
  } state_e;

  state_e                      state_q;
  logic [KW-1:0]               k_q;
  logic [AB_W-1:0]             a_q;
  logic [AB_W-1:0]             b_q;
  logic signed [ACC_WIDTH-1:0] acc_q [NEL];
  logic signed [ACC_WIDTH-1:0] acc_d [NEL];
  logic signed [PW-1:0]        prod  [NEL];
  logic [CD_W-1:0]             d_q;
  logic                        out_valid_q;
  logic                        busy_q;
  logic                        overflow_q;
  logic                        sat_hit;
  logic                        accept;
  int                          k_i;

`ifdef TC_SATURATE_EN
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  logic [ACC_WIDTH:0] sum_w [NEL];
`endif

  assign bus.in_ready  = (state_q == S_IDLE) & mma_enable;
  assign bus.out_valid = out_valid_q;
  assign bus.d_out     = d_q;
  assign busy          = busy_q;
  assign overflow      = overflow_q;
  assign accept        = bus.in_valid & bus.in_ready;

  // Rank-1 update for the current k; k==DIM is the capture cycle and reuses column 0 harmlessly.
  always_comb begin
    sat_hit = 1'b0;
    k_i     = (k_q < KW'(DIM)) ? int'(k_q) : 0;
    for (int i = 0; i < DIM_I; i++) begin
      for (int j = 0; j < DIM_I; j++) begin
        prod[i*DIM_I+j] = PW'($signed(a_q[(i*DIM_I + k_i)*int'(IN_WIDTH) +: IN_WIDTH]))
                        * PW'($signed(b_q[(k_i*DIM_I + j)*int'(IN_WIDTH) +: IN_WIDTH]));
      end
    end
    for (int n = 0; n < NEL_I; n++) begin
`ifdef TC_SATURATE_EN
      sum_w[n] = {acc_q[n][ACC_WIDTH-1], acc_q[n]} + (ACC_WIDTH+1)'(prod[n]);
      if (sum_w[n][ACC_WIDTH] != sum_w[n][ACC_WIDTH-1]) begin
        sat_hit  = 1'b1;
        acc_d[n] = sum_w[n][ACC_WIDTH] ? ACC_MIN : ACC_MAX;
      end else begin
        acc_d[n] = sum_w[n][ACC_WIDTH-1:0];
      end
`else
      acc_d[n] = acc_q[n] + ACC_WIDTH'(prod[n]);
`endif
    end
  end

  // Control FSM plus datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      d_q         <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overflow_q  <= 1'b0;
      for (int n = 0; n < NEL_I; n++) acc_q[n] <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            a_q        <= bus.a_in;
            b_q        <= bus.b_in;
            k_q        <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= S_COMPUTE;
            for (int n = 0; n < NEL_I; n++) begin
              acc_q[n] <= bus.acc_en ? bus.c_in[n*int'(ACC_WIDTH) +: ACC_WIDTH] : '0;
            end
          end
        end
        S_COMPUTE: begin
          if (k_q == KW'(DIM)) begin
            for (int n = 0; n < NEL_I; n++) d_q[n*int'(ACC_WIDTH) +: ACC_WIDTH] <= acc_q[n];
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            for (int n = 0; n < NEL_I; n++) acc_q[n] <= acc_d[n];
            k_q        <= k_q + KW'(1);
            overflow_q <= overflow_q | sat_hit;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_tensor_core_mma_seq.sv
// Randomised self-checking bench for tensor_core_mma_seq against a plain-arithmetic tile model.
module tb_tensor_core_mma_seq;
  localparam int DIM = 4;
  localparam int IW  = 8;
  localparam int AW  = 32;
  localparam int NEL = DIM * DIM;
  localparam int ABW = NEL * IW;
  localparam int DW  = NEL * AW;

  logic clk = 1'b0;
  logic rst;
  logic mma_enable;
  logic busy;
  logic overflow;

  int n_cmp = 0;
  int n_bad = 0;

  tensor_core_mma_seq_if #(.DIM(DIM), .IN_WIDTH(IW), .ACC_WIDTH(AW)) bus ();

  tensor_core_mma_seq #(.DIM(DIM), .IN_WIDTH(IW), .ACC_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .mma_enable (mma_enable),
    .bus        (bus),
    .busy       (busy),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: D(i,j) = C(i,j) + sum_k A(i,k)*B(k,j), wrapped or clamped after each k.
  function automatic logic [DW-1:0] model(input logic [ABW-1:0] a, input logic [ABW-1:0] b,
                                          input logic [DW-1:0] c, input bit acc_en,
                                          output bit ovf);
    logic [DW-1:0] d;
    longint acc;
    longint mx;
    longint mn;
    mx  = (longint'(1) <<< (AW - 1)) - 1;
    mn  = -mx - 1;
    ovf = 1'b0;
    d   = '0;
    for (int i = 0; i < DIM; i++) begin
      for (int j = 0; j < DIM; j++) begin
        acc = acc_en ? longint'($signed(c[(i*DIM+j)*AW +: AW])) : 64'sd0;
        for (int k = 0; k < DIM; k++) begin
          acc += longint'($signed(a[(i*DIM+k)*IW +: IW])) * longint'($signed(b[(k*DIM+j)*IW +: IW]));
`ifdef TC_SATURATE_EN
          if (acc > mx) begin acc = mx; ovf = 1'b1; end
          else if (acc < mn) begin acc = mn; ovf = 1'b1; end
`else
          acc = (acc <<< (64 - AW)) >>> (64 - AW);
`endif
        end
        d[(i*DIM+j)*AW +: AW] = acc[AW-1:0];
      end
    end
    return d;
  endfunction

  function automatic logic [ABW-1:0] fill_ab(input int v);
    logic [ABW-1:0] t;
    for (int n = 0; n < NEL; n++) t[n*IW +: IW] = IW'(v);
    return t;
  endfunction

  function automatic logic [DW-1:0] fill_c(input logic [AW-1:0] v);
    logic [DW-1:0] t;
    for (int n = 0; n < NEL; n++) t[n*AW +: AW] = v;
    return t;
  endfunction

  function automatic logic [ABW-1:0] rnd_ab();
    logic [ABW-1:0] t;
    for (int n = 0; n < NEL; n++) begin
      case ($urandom_range(0, 3))
        0:       t[n*IW +: IW] = 8'h80;
        1:       t[n*IW +: IW] = 8'h7F;
        default: t[n*IW +: IW] = IW'($urandom);
      endcase
    end
    return t;
  endfunction

  function automatic logic [DW-1:0] rnd_c();
    logic [DW-1:0] t;
    for (int n = 0; n < NEL; n++) begin
      case ($urandom_range(0, 3))
        0:       t[n*AW +: AW] = 32'h7FFF_FFF0 + AW'($urandom_range(0, 15));
        1:       t[n*AW +: AW] = 32'h8000_0000 + AW'($urandom_range(0, 15));
        default: t[n*AW +: AW] = AW'($urandom);
      endcase
    end
    return t;
  endfunction

  // One full operation: accept, latency, result, optional backpressure, output handshake.
  task automatic run_op(input string tag, input logic [ABW-1:0] a, input logic [ABW-1:0] b,
                        input logic [DW-1:0] c, input bit acc_en, input int hold, input bit drop_en);
    logic [DW-1:0] exp_d;
    bit            exp_ovf;
    int            t;
    exp_d = model(a, b, c, acc_en, exp_ovf);
    @(negedge clk);
    bus.a_in      = a;
    bus.b_in      = b;
    bus.c_in      = c;
    bus.acc_en    = acc_en;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    t = 0;
    while (!bus.in_ready && t < 20) begin @(negedge clk); t++; end
    check({tag, "/accept"}, DW'(t < 20), DW'(1));
    if (t >= 20) begin bus.in_valid = 1'b0; return; end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a_in     = rnd_ab();
    bus.b_in     = rnd_ab();
    bus.c_in     = rnd_c();
    bus.acc_en   = 1'($urandom);
    if (drop_en) mma_enable = 1'b0;
    t = 0;
    while (!bus.out_valid && t < 40) begin @(posedge clk); #1; t++; end
    check({tag, "/latency"}, DW'(t), DW'(DIM + 1));
    check({tag, "/d_out"}, bus.d_out, exp_d);
    check({tag, "/overflow"}, DW'(overflow), DW'(exp_ovf));
    check({tag, "/busy"}, DW'(busy), DW'(1));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check({tag, "/hold_valid"}, DW'(bus.out_valid), DW'(1));
      check({tag, "/hold_d"}, bus.d_out, exp_d);
      check({tag, "/hold_in_ready"}, DW'(bus.in_ready), DW'(0));
      check({tag, "/hold_busy"}, DW'(busy), DW'(1));
    end
    // New operands offered during the output handshake must be refused.
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    check({tag, "/rel_valid"}, DW'(bus.out_valid), DW'(0));
    check({tag, "/rel_busy"}, DW'(busy), DW'(0));
    check({tag, "/rel_in_ready"}, DW'(bus.in_ready), DW'(mma_enable));
    check({tag, "/rel_d_kept"}, bus.d_out, exp_d);
    mma_enable = 1'b1;
  endtask

  initial begin
    logic [ABW-1:0] a1;
    logic [DW-1:0]  c1;
    int             t;

    rst           = 1'b1;
    mma_enable    = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.acc_en    = 1'b0;
    bus.a_in      = '0;
    bus.b_in      = '0;
    bus.c_in      = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset/out_valid", DW'(bus.out_valid), DW'(0));
    check("reset/busy", DW'(busy), DW'(0));
    check("reset/overflow", DW'(overflow), DW'(0));
    check("reset/d_out", bus.d_out, '0);
    check("reset/in_ready", DW'(bus.in_ready), DW'(1));
    rst = 1'b0;

    // Basic tile with absolute expectations as well as the model.
    a1 = fill_ab(1);
    for (int i = 0; i < DIM; i++) a1[(i*DIM+i)*IW +: IW] = 8'd2;
    c1 = '0;
    c1[(0*DIM+0)*AW +: AW] = 32'd3;
    c1[(2*DIM+0)*AW +: AW] = 32'd2;
    c1[(2*DIM+2)*AW +: AW] = 32'd5;
    run_op("basic", a1, fill_ab(1), c1, 1'b1, 6, 1'b0);
    check("basic/D00", DW'(bus.d_out[0 +: AW]), DW'(8));
    check("basic/D01", DW'(bus.d_out[AW +: AW]), DW'(5));
    check("basic/D20", DW'(bus.d_out[(2*DIM)*AW +: AW]), DW'(7));
    check("basic/D22", DW'(bus.d_out[(2*DIM+2)*AW +: AW]), DW'(10));

    run_op("no_acc", a1, fill_ab(1), fill_c(32'd99), 1'b0, 0, 1'b0);
    check("no_acc/D33", DW'(bus.d_out[(NEL-1)*AW +: AW]), DW'(5));

    run_op("neg128", fill_ab(-128), fill_ab(-128), '0, 1'b1, 1, 1'b0);
    check("neg128/D11", DW'(bus.d_out[(DIM+1)*AW +: AW]), DW'(65536));
    run_op("m1x127", fill_ab(-1), fill_ab(127), '0, 1'b1, 0, 1'b1);
    check("m1x127/D00", DW'(bus.d_out[0 +: AW]), DW'(32'hFFFF_FE04));

    run_op("ovf", fill_ab(1), fill_ab(1), fill_c(32'h7FFF_FFFF), 1'b1, 2, 1'b0);
`ifdef TC_SATURATE_EN
    check("ovf/D00", DW'(bus.d_out[0 +: AW]), DW'(32'h7FFF_FFFF));
    check("ovf/flag", DW'(overflow), DW'(1));
`else
    check("ovf/D00", DW'(bus.d_out[0 +: AW]), DW'(32'h8000_0003));
    check("ovf/flag", DW'(overflow), DW'(0));
`endif

    for (int r = 0; r < 20; r++) begin
      run_op("rand", rnd_ab(), rnd_ab(), rnd_c(), 1'($urandom), $urandom_range(0, 3),
             ($urandom_range(0, 7) == 0));
    end

    // Reset in the middle of COMPUTE at k == 2.
    @(negedge clk);
    bus.a_in     = rnd_ab();
    bus.b_in     = rnd_ab();
    bus.c_in     = rnd_c();
    bus.acc_en   = 1'b1;
    bus.in_valid = 1'b1;
    t = 0;
    while (!bus.in_ready && t < 20) begin @(negedge clk); t++; end
    check("midrst/accept", DW'(t < 20), DW'(1));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("midrst/busy_before", DW'(busy), DW'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst/out_valid", DW'(bus.out_valid), DW'(0));
    check("midrst/busy", DW'(busy), DW'(0));
    check("midrst/d_out", bus.d_out, '0);
    check("midrst/in_ready", DW'(bus.in_ready), DW'(1));
    run_op("after_rst", a1, fill_ab(1), c1, 1'b1, 0, 1'b0);

    // mma_enable low refuses new operands.
    @(negedge clk);
    mma_enable   = 1'b0;
    bus.in_valid = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      check("disabled/in_ready", DW'(bus.in_ready), DW'(0));
      check("disabled/busy", DW'(busy), DW'(0));
    end
    bus.in_valid = 1'b0;
    mma_enable   = 1'b1;
    @(posedge clk); #1;
    check("disabled/out_valid", DW'(bus.out_valid), DW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
